// File: rtl/mmio_responder_pkg.sv
// mmio_pkg: shared constants for the MMIO responder.
//   - register offsets inside the 8-word window
//   - TMR_CTRL bit positions
//   - window size
package mmio_pkg;
  localparam int WIN_WORDS = 8;
  localparam int WIN_SHIFT = $clog2(WIN_WORDS);

  localparam logic [2:0] OFF_LED       = 3'd0;
  localparam logic [2:0] OFF_SW        = 3'd1;
  localparam logic [2:0] OFF_SW_EDGE   = 3'd2;
  localparam logic [2:0] OFF_TMR_CTRL  = 3'd3;
  localparam logic [2:0] OFF_TMR_COUNT = 3'd4;
  localparam logic [2:0] OFF_TMR_CMP   = 3'd5;
  localparam logic [2:0] OFF_TMR_STAT  = 3'd6;
  localparam logic [2:0] OFF_SCRATCH   = 3'd7;

  localparam int CTRL_W      = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;
endpackage

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU memory-bus control signals seen by the responder.
//   CS, WE, ADDR : from the CPU (master drives, slave samples)
//   Mem_CS       : chip select forwarded to the memory (slave drives)
// The 32-bit data bus stays a plain inout on the responder, since it is a
// resolved net shared with the memory and the CPU.
interface mmio_responder_if;
  logic       CS;
  logic       WE;
  logic [6:0] ADDR;
  logic       Mem_CS;

  modport master (output CS, WE, ADDR, input Mem_CS);
  modport slave  (input CS, WE, ADDR, output Mem_CS);
endinterface

// File: rtl/mmio_responder_timer.sv
// mmio_timer: 32-bit compare timer, state updated on the falling edge.
// Ports:
//   CLK, RST           clock / synchronous active-high reset
//   ctrl               TMR_CTRL bits (enable, auto-reload, irq enable)
//   wr_count/cmp/stat  bus write strobes, wdata the bus data
//   count, cmp, flag   timer state; irq = flag & irq enable
module mmio_timer
  import mmio_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              wr_count,
  input  logic              wr_cmp,
  input  logic              wr_stat,
  input  logic [31:0]       wdata,
  output logic [31:0]       count,
  output logic [31:0]       cmp,
  output logic              flag,
  output logic              irq
);
  logic match;

  // Compare uses the registered cmp, so writing cmp == count only takes
  // effect at the following edge.
  assign match = ctrl[CTRL_EN] && (count == cmp);
  assign irq   = flag & ctrl[CTRL_IRQ_EN];

  always_ff @(negedge CLK) begin
    if (RST) begin
      count <= '0;
      cmp   <= '0;
      flag  <= 1'b0;
    end else begin
      // bus write wins over increment and reload
      if (wr_count)
        count <= wdata;
      else if (ctrl[CTRL_EN])
        count <= (match && ctrl[CTRL_RELOAD]) ? '0 : count + 32'd1;
      if (wr_cmp)
        cmp <= wdata;
      // a new match wins over W1C
      if (match)
        flag <= 1'b1;
      else if (wr_stat && wdata[0])
        flag <= 1'b0;
    end
  end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO window at the top of the word address space.
// Offsets: 0 LED, 1 SW, 2 SW_EDGE (W1C), 3 TMR_CTRL, 4 TMR_COUNT,
//          5 TMR_CMP, 6 TMR_STAT (W1C), 7 SCRATCH.
// Ports:
//   CLK, RST   clock (falling-edge state) / synchronous active-high reset
//   bus        CS, WE, ADDR in; Mem_CS out (= CS & ~hit)
//   Mem_Bus    shared 32-bit data bus, driven only while CS & ~WE & hit
//   SW         asynchronous switches; LED register out; IRQ timer interrupt
// Build option: define MMIO_TIMER_EN to include the timer (offsets 3-6, IRQ).
// Without it those offsets read 0, ignore writes, and IRQ is 0.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR = 7'h78,
  parameter int         SW_W      = 8
) (
  input  logic            CLK,
  input  logic            RST,
  mmio_responder_if.slave bus,
  inout  wire  [31:0]     Mem_Bus,
  input  logic [SW_W-1:0] SW,
  output logic [SW_W-1:0] LED,
  output logic            IRQ
);
  logic            hit;
  logic            wr;
  logic [2:0]      off;
  logic [31:0]     wdata;
  logic [31:0]     rd_mux;
  logic [31:0]     rd_data;
  logic [SW_W-1:0] sw_s1, sw_s2, sw_edge;
  logic [31:0]     scratch;

  assign hit   = (bus.ADDR >> WIN_SHIFT) == (BASE_ADDR >> WIN_SHIFT);
  assign off   = bus.ADDR[2:0];
  assign wr    = bus.CS & bus.WE & hit;
  assign wdata = Mem_Bus;

  // memory is deselected whenever we own the access, so one driver only
  assign bus.Mem_CS = bus.CS & ~hit;
  assign Mem_Bus    = (bus.CS & ~bus.WE & hit) ? rd_data : 'z;

`ifdef MMIO_TIMER_EN
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       tmr_count, tmr_cmp;
  logic              tmr_flag;

  mmio_timer u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .ctrl     (ctrl),
    .wr_count (wr && off == OFF_TMR_COUNT),
    .wr_cmp   (wr && off == OFF_TMR_CMP),
    .wr_stat  (wr && off == OFF_TMR_STAT),
    .wdata    (wdata),
    .count    (tmr_count),
    .cmp      (tmr_cmp),
    .flag     (tmr_flag),
    .irq      (IRQ)
  );

  always_ff @(negedge CLK) begin
    if (RST)
      ctrl <= '0;
    else if (wr && off == OFF_TMR_CTRL)
      ctrl <= wdata[CTRL_W-1:0];
  end
`else
  assign IRQ = 1'b0;
`endif

  // read mux has no side effects, so a held CS re-reads the same value
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_LED:       rd_mux = 32'(LED);
      OFF_SW:        rd_mux = 32'(sw_s2);
      OFF_SW_EDGE:   rd_mux = 32'(sw_edge);
`ifdef MMIO_TIMER_EN
      OFF_TMR_CTRL:  rd_mux = 32'(ctrl);
      OFF_TMR_COUNT: rd_mux = tmr_count;
      OFF_TMR_CMP:   rd_mux = tmr_cmp;
      OFF_TMR_STAT:  rd_mux = 32'(tmr_flag);
`endif
      OFF_SCRATCH:   rd_mux = scratch;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      LED     <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      sw_edge <= '0;
      scratch <= '0;
      rd_data <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      // rising edge = stage1 high while stage2 still low; it wins over W1C
      sw_edge <= (sw_edge & ~((wr && off == OFF_SW_EDGE) ? wdata[SW_W-1:0] : '0))
               | (sw_s1 & ~sw_s2);
      if (wr && off == OFF_LED)
        LED <= wdata[SW_W-1:0];
      if (wr && off == OFF_SCRATCH)
        scratch <= wdata;
      if (bus.CS && hit)
        rd_data <= rd_mux;
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed test plan plus randomized bus traffic,
// checked every falling edge against a register-level reference model.
module tb_mmio_responder;
  localparam logic [6:0] BASE = 7'h78;
  localparam int         SW_W = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic [SW_W-1:0] SW;
  logic [SW_W-1:0] LED;
  logic            IRQ;
  logic [31:0]     cpu_wd;
  logic [31:0]     mem_word;
  wire  [31:0]     mem_bus;

  mmio_responder_if bus_if ();

  // CPU drives write data; memory answers reads when selected
  assign mem_word = 32'hA5A5_0000 | {25'd0, bus_if.ADDR};
  assign mem_bus  = (bus_if.CS & bus_if.WE) ? cpu_wd : 'z;
  assign mem_bus  = (bus_if.Mem_CS & ~bus_if.WE) ? mem_word : 'z;

  always #5 CLK = ~CLK;

  mmio_responder #(.BASE_ADDR(BASE), .SW_W(SW_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus_if),
    .Mem_Bus (mem_bus),
    .SW      (SW),
    .LED     (LED),
    .IRQ     (IRQ)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_led, m_s1, m_s2, m_edge, m_scratch, m_rd;
  logic [31:0] m_ctrl, m_count, m_cmp;
  logic        m_flag;

  function automatic logic [31:0] m_read(input int o);
    case (o)
      0: return m_led;
      1: return m_s2;
      2: return m_edge;
      7: return m_scratch;
`ifdef MMIO_TIMER_EN
      3: return m_ctrl;
      4: return m_count;
      5: return m_cmp;
      6: return {31'd0, m_flag};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_hit();
    return (int'(bus_if.ADDR) / 8) == (int'(BASE) / 8);
  endfunction

  task automatic model_step();
    int          o;
    logic        wr, match;
    logic [31:0] nrd, nedge, ncount;
    logic        nflag;
    o  = int'(bus_if.ADDR) % 8;
    wr = bus_if.CS && bus_if.WE && m_hit();
    if (RST) begin
      m_led = 0; m_s1 = 0; m_s2 = 0; m_edge = 0; m_scratch = 0; m_rd = 0;
      m_ctrl = 0; m_count = 0; m_cmp = 0; m_flag = 0;
      return;
    end
    nrd   = (bus_if.CS && m_hit()) ? m_read(o) : m_rd;
    nedge = (m_edge & ~((wr && o == 2) ? (cpu_wd & 32'hFF) : 32'd0)) | (m_s1 & ~m_s2);
    m_s2  = m_s1;
    m_s1  = 32'(SW);
    m_edge = nedge;
    m_rd  = nrd;
    if (wr && o == 0) m_led = cpu_wd & 32'hFF;
    if (wr && o == 7) m_scratch = cpu_wd;
`ifdef MMIO_TIMER_EN
    match  = m_ctrl[0] && (m_count == m_cmp);
    ncount = m_count;
    if (wr && o == 4) ncount = cpu_wd;
    else if (m_ctrl[0]) ncount = (match && m_ctrl[1]) ? 32'd0 : m_count + 1;
    nflag = m_flag;
    if (match) nflag = 1;
    else if (wr && o == 6 && cpu_wd[0]) nflag = 0;
    if (wr && o == 5) m_cmp = cpu_wd;
    if (wr && o == 3) m_ctrl = cpu_wd & 32'h7;
    m_count = ncount;
    m_flag  = nflag;
`else
    match = 1'b0;
    ncount = 32'd0;
    nflag = match;
    m_count = ncount;
    m_flag = nflag;
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic cs, input logic we, input logic [6:0] a, input logic [31:0] d);
    bus_if.CS = cs; bus_if.WE = we; bus_if.ADDR = a; cpu_wd = d;
  endtask

  task automatic cycle();
    logic exp_irq;
    @(negedge CLK);
    model_step();
    #1;
`ifdef MMIO_TIMER_EN
    exp_irq = m_flag & m_ctrl[2];
`else
    exp_irq = 1'b0;
`endif
    chk("led", 32'(LED), m_led);
    chk("irq", 32'(IRQ), 32'(exp_irq));
    chk("mem_cs", 32'(bus_if.Mem_CS), 32'(bus_if.CS && !m_hit()));
    if (bus_if.CS && !bus_if.WE && m_hit()) chk("rd_bus", mem_bus, m_rd);
    if (bus_if.CS && !bus_if.WE && !m_hit()) chk("mem_pass", mem_bus, mem_word);
  endtask

  task automatic wr_reg(input logic [2:0] o, input logic [31:0] d);
    drive(1'b1, 1'b1, BASE | {4'd0, o}, d);
    cycle();
    drive(1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  // two-cycle load, returns the value seen on each cycle
  task automatic rd_reg(input logic [2:0] o, output logic [31:0] d1, output logic [31:0] d2);
    drive(1'b1, 1'b0, BASE | {4'd0, o}, 32'd0);
    cycle(); d1 = mem_bus;
    cycle(); d2 = mem_bus;
    drive(1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  logic [31:0] d1, d2;

  initial begin
    RST = 1'b1; SW = '0;
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    m_led = 0; m_s1 = 0; m_s2 = 0; m_edge = 0; m_scratch = 0; m_rd = 0;
    m_ctrl = 0; m_count = 0; m_cmp = 0; m_flag = 0;
    cycle(); cycle();
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    RST = 1'b0;
    rd_reg(3'd7, d1, d2);
    chk("rst_scratch", d1, 32'd0);

    // LED write/read
    wr_reg(3'd0, 32'h0000_00A5);
    chk("led_a5", 32'(LED), 32'hA5);
    rd_reg(3'd0, d1, d2);
    chk("led_rd1", d1, 32'hA5);
    chk("led_rd2", d2, 32'hA5);

    // access outside the window passes to memory
    drive(1'b1, 1'b0, 7'h10, 32'd0);
    cycle();
    chk("out_mem_cs", 32'(bus_if.Mem_CS), 32'd1);
    chk("out_data", mem_bus, 32'hA5A5_0010);
    drive(1'b0, 1'b0, 7'd0, 32'd0);

    // switches, edge capture, W1C, repeated read
    SW = 8'h81;
    cycle(); cycle();
    rd_reg(3'd1, d1, d2);
    chk("sw_81", d1, 32'h81);
    rd_reg(3'd2, d1, d2);
    chk("edge_81", d1, 32'h81);
    wr_reg(3'd2, 32'h1);
    rd_reg(3'd2, d1, d2);
    chk("edge_80a", d1, 32'h80);
    chk("edge_80b", d2, 32'h80);

`ifdef MMIO_TIMER_EN
    wr_reg(3'd5, 32'd5);
    wr_reg(3'd4, 32'd0);
    wr_reg(3'd3, 32'h7);
    repeat (5) cycle();
    chk("tmr_pre", 32'(IRQ), 32'd0);
    cycle();
    chk("tmr_irq", 32'(IRQ), 32'd1);
    rd_reg(3'd4, d1, d2);
    chk("tmr_reload", d1, 32'd0);
    wr_reg(3'd6, 32'h1);
    chk("tmr_w1c", 32'(IRQ), 32'd0);
    wr_reg(3'd4, 32'd0);
    repeat (5) cycle();
    wr_reg(3'd6, 32'h1);
    chk("tmr_w1c_lose", 32'(IRQ), 32'd1);
    wr_reg(3'd6, 32'h1);
    chk("tmr_w1c2", 32'(IRQ), 32'd0);
    wr_reg(3'd3, 32'h1);
    wr_reg(3'd4, 32'hFFFF_FFFE);
    drive(1'b1, 1'b0, BASE | 7'd4, 32'd0);
    cycle(); chk("wrap0", mem_bus, 32'hFFFF_FFFE);
    cycle(); chk("wrap1", mem_bus, 32'hFFFF_FFFF);
    cycle(); chk("wrap2", mem_bus, 32'd0);
    cycle(); chk("wrap3", mem_bus, 32'd1);
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    wr_reg(3'd3, 32'h0);
`else
    wr_reg(3'd3, 32'h7);
    wr_reg(3'd5, 32'h5);
    rd_reg(3'd3, d1, d2);
    chk("notmr_ctrl", d1, 32'd0);
    rd_reg(3'd5, d1, d2);
    chk("notmr_cmp", d1, 32'd0);
    chk("notmr_irq", 32'(IRQ), 32'd0);
`endif

    // reset in the middle of a SCRATCH write
    drive(1'b1, 1'b1, BASE | 7'd7, 32'hDEAD_BEEF);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 32'd0);
    cycle();
    chk("rstw_led", 32'(LED), 32'd0);
    chk("rstw_irq", 32'(IRQ), 32'd0);
    rd_reg(3'd7, d1, d2);
    chk("rstw_scratch", d1, 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [6:0] a;
      a = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a = BASE | {4'd0, a[2:0]};
      drive($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) SW = 8'($urandom);
      RST = ($urandom_range(0, 99) == 0);
      cycle();
    end
    RST = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
